// File: rtl/alu_ctrl_stage_if.sv
// Handshake and decode-field bundle for alu_ctrl_stage.
// The stage takes the slave side and the producer/consumer environment takes the master side.
interface alu_ctrl_stage_if;
    logic       valid_i;
    logic       ready_o;
    logic [2:0] aluop_i;
    logic [2:0] funct3_i;
    logic [6:0] funct7_i;
    logic       valid_o;
    logic       ready_i;
    logic [4:0] alu_ctrl_o;
    logic       illegal_o;
    logic       flush_i;

    modport slave (
        input  valid_i, aluop_i, funct3_i, funct7_i, ready_i, flush_i,
        output ready_o, valid_o, alu_ctrl_o, illegal_o
    );

    modport master (
        output valid_i, aluop_i, funct3_i, funct7_i, ready_i, flush_i,
        input  ready_o, valid_o, alu_ctrl_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ALU control decode feeding a 2-entry skid buffer (OUT + SKID) with a registered ready_o.
// Define ALU_CTRL_ILLEGAL_EN to store and report an illegal-combination flag with each entry.
module alu_ctrl_stage (
    input  logic               clk_i,
    input  logic               rst_i,
    alu_ctrl_stage_if.slave    bus
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    localparam logic [4:0] OP_ADD   = 5'd0;
    localparam logic [4:0] OP_SUB   = 5'd1;
    localparam logic [4:0] OP_SLL   = 5'd2;
    localparam logic [4:0] OP_SLT   = 5'd3;
    localparam logic [4:0] OP_SLTU  = 5'd4;
    localparam logic [4:0] OP_XOR   = 5'd5;
    localparam logic [4:0] OP_SRL   = 5'd6;
    localparam logic [4:0] OP_SRA   = 5'd7;
    localparam logic [4:0] OP_OR    = 5'd8;
    localparam logic [4:0] OP_AND   = 5'd9;
    localparam logic [4:0] OP_BEQ   = 5'd10;
    localparam logic [4:0] OP_BNE   = 5'd11;
    localparam logic [4:0] OP_BLT   = 5'd12;
    localparam logic [4:0] OP_BGE   = 5'd13;
    localparam logic [4:0] OP_BLTU  = 5'd14;
    localparam logic [4:0] OP_BGEU  = 5'd15;
    localparam logic [4:0] OP_PASSB = 5'd16;
    localparam logic [4:0] OP_JUMP  = 5'd17;

    typedef struct packed {
        logic [4:0] ctrl;
`ifdef ALU_CTRL_ILLEGAL_EN
        logic       ill;
`endif
    } entry_t;

    state_t state_q, state_d;
    entry_t out_q, out_d;
    entry_t skid_q, skid_d;
    logic   ready_q, ready_d;

    logic   [4:0] decCtrl;
    logic         decIll;
    entry_t       decEntry;
    logic         inXfer;
    logic         outXfer;

    // Illegal combinations always collapse to ADD; the macro only decides whether the flag is kept.
    always_comb begin
        decCtrl = OP_ADD;
        decIll  = 1'b0;
        case (bus.aluop_i)
            3'd0, 3'd1: begin
                case (bus.funct3_i)
                    3'b000: decCtrl = (bus.aluop_i == 3'd0 && bus.funct7_i[5]) ? OP_SUB : OP_ADD;
                    3'b001: decCtrl = OP_SLL;
                    3'b010: decCtrl = OP_SLT;
                    3'b011: decCtrl = OP_SLTU;
                    3'b100: decCtrl = OP_XOR;
                    3'b101: decCtrl = bus.funct7_i[5] ? OP_SRA : OP_SRL;
                    3'b110: decCtrl = OP_OR;
                    3'b111: decCtrl = OP_AND;
                endcase
                if (bus.aluop_i == 3'd0) begin
                    decIll = !((bus.funct7_i == 7'h00) ||
                               ((bus.funct7_i == 7'h20) &&
                                (bus.funct3_i == 3'b000 || bus.funct3_i == 3'b101)));
                end else if (bus.funct3_i == 3'b001) begin
                    decIll = (bus.funct7_i != 7'h00);
                end else if (bus.funct3_i == 3'b101) begin
                    decIll = !(bus.funct7_i == 7'h00 || bus.funct7_i == 7'h20);
                end
            end
            3'd2: begin
                case (bus.funct3_i)
                    3'b000: decCtrl = OP_BEQ;
                    3'b001: decCtrl = OP_BNE;
                    3'b100: decCtrl = OP_BLT;
                    3'b101: decCtrl = OP_BGE;
                    3'b110: decCtrl = OP_BLTU;
                    3'b111: decCtrl = OP_BGEU;
                    default: decIll = 1'b1;
                endcase
            end
            3'd3:       decCtrl = OP_JUMP;
            3'd4, 3'd5: decCtrl = OP_ADD;
            3'd6:       decCtrl = OP_PASSB;
            3'd7:       decIll  = 1'b1;
        endcase
        if (decIll) begin
            decCtrl = OP_ADD;
        end
    end

    always_comb begin
        decEntry      = '0;
        decEntry.ctrl = decCtrl;
`ifdef ALU_CTRL_ILLEGAL_EN
        decEntry.ill  = decIll;
`endif
    end

    assign inXfer  = bus.valid_i && ready_q;
    assign outXfer = (state_q != EMPTY) && bus.ready_i;

    // Entries always leave from OUT, so SKID only fills when OUT is stalled.
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (inXfer) begin
                    state_d = ONE;
                    out_d   = decEntry;
                end
            end
            ONE: begin
                if (inXfer && !outXfer) begin
                    state_d = TWO;
                    skid_d  = decEntry;
                end else if (inXfer && outXfer) begin
                    out_d   = decEntry;
                end else if (outXfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (outXfer) begin
                    state_d = ONE;
                    out_d   = skid_q;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (bus.flush_i) begin
            state_d = EMPTY;
            out_d   = '0;
            skid_d  = '0;
        end
        ready_d = (state_d != TWO);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

    assign bus.ready_o    = ready_q;
    assign bus.valid_o    = (state_q != EMPTY);
    assign bus.alu_ctrl_o = out_q.ctrl;
`ifdef ALU_CTRL_ILLEGAL_EN
    assign bus.illegal_o  = out_q.ill;
`else
    assign bus.illegal_o  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode vector table plus skid, flush and reset sequences.
// Expected illegal_o follows ALU_CTRL_ILLEGAL_EN.
module tb_alu_ctrl_stage;

`ifdef ALU_CTRL_ILLEGAL_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct {
        logic [2:0] aluop;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] ctrl;
        logic       ill;
    } vec_t;

    logic clk;
    logic rst;
    int   totalCount;
    int   badCount;
    vec_t vecs[24];

    alu_ctrl_stage_if bus();

    alu_ctrl_stage dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [2:0] op, input logic [2:0] f3, input logic [6:0] f7);
        bus.valid_i  = v;
        bus.aluop_i  = op;
        bus.funct3_i = f3;
        bus.funct7_i = f7;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCount++;
        if (act !== exp) begin
            badCount++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        totalCount = 0;
        badCount   = 0;

        vecs[0]  = '{3'd0, 3'b000, 7'h20, 5'd1,  1'b0};
        vecs[1]  = '{3'd0, 3'b000, 7'h00, 5'd0,  1'b0};
        vecs[2]  = '{3'd1, 3'b000, 7'h20, 5'd0,  1'b0};
        vecs[3]  = '{3'd1, 3'b101, 7'h20, 5'd7,  1'b0};
        vecs[4]  = '{3'd1, 3'b101, 7'h00, 5'd6,  1'b0};
        vecs[5]  = '{3'd0, 3'b001, 7'h00, 5'd2,  1'b0};
        vecs[6]  = '{3'd0, 3'b010, 7'h00, 5'd3,  1'b0};
        vecs[7]  = '{3'd0, 3'b011, 7'h00, 5'd4,  1'b0};
        vecs[8]  = '{3'd0, 3'b100, 7'h00, 5'd5,  1'b0};
        vecs[9]  = '{3'd0, 3'b101, 7'h20, 5'd7,  1'b0};
        vecs[10] = '{3'd0, 3'b110, 7'h00, 5'd8,  1'b0};
        vecs[11] = '{3'd0, 3'b111, 7'h00, 5'd9,  1'b0};
        vecs[12] = '{3'd2, 3'b101, 7'h00, 5'd13, 1'b0};
        vecs[13] = '{3'd2, 3'b110, 7'h00, 5'd14, 1'b0};
        vecs[14] = '{3'd2, 3'b111, 7'h00, 5'd15, 1'b0};
        vecs[15] = '{3'd2, 3'b010, 7'h00, 5'd0,  1'b1};
        vecs[16] = '{3'd3, 3'b000, 7'h00, 5'd17, 1'b0};
        vecs[17] = '{3'd5, 3'b010, 7'h00, 5'd0,  1'b0};
        vecs[18] = '{3'd6, 3'b000, 7'h00, 5'd16, 1'b0};
        vecs[19] = '{3'd7, 3'b000, 7'h00, 5'd0,  1'b1};
        vecs[20] = '{3'd0, 3'b000, 7'h01, 5'd0,  1'b1};
        vecs[21] = '{3'd0, 3'b001, 7'h20, 5'd0,  1'b1};
        vecs[22] = '{3'd1, 3'b001, 7'h20, 5'd0,  1'b1};
        vecs[23] = '{3'd1, 3'b011, 7'h7f, 5'd4,  1'b0};

        rst = 1'b1;
        bus.flush_i = 1'b0;
        bus.ready_i = 1'b1;
        applyStimulus(1'b0, 3'd0, 3'd0, 7'd0);
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset valid_o", {31'd0, bus.valid_o}, 0);
        checkOutput("reset ready_o", {31'd0, bus.ready_o}, 0);
        checkOutput("reset alu_ctrl_o", {27'd0, bus.alu_ctrl_o}, 0);
        checkOutput("reset illegal_o", {31'd0, bus.illegal_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post-reset ready_o", {31'd0, bus.ready_o}, 1);
        checkOutput("post-reset valid_o", {31'd0, bus.valid_o}, 0);

        $display("[TB] decode vector table");
        for (int i = 0; i < 24; i++) begin
            applyStimulus(1'b1, vecs[i].aluop, vecs[i].f3, vecs[i].f7);
            @(negedge clk);
            applyStimulus(1'b0, 3'd0, 3'd0, 7'd0);
            checkOutput($sformatf("vec%0d valid_o", i), {31'd0, bus.valid_o}, 1);
            checkOutput($sformatf("vec%0d alu_ctrl_o", i), {27'd0, bus.alu_ctrl_o}, {27'd0, vecs[i].ctrl});
            checkOutput($sformatf("vec%0d illegal_o", i), {31'd0, bus.illegal_o}, {31'd0, vecs[i].ill & ILL_EN});
            @(negedge clk);
            checkOutput($sformatf("vec%0d valid_o drop", i), {31'd0, bus.valid_o}, 0);
        end

        $display("[TB] skid fill and drain");
        bus.ready_i = 1'b0;
        applyStimulus(1'b1, 3'd2, 3'b000, 7'd0);
        @(negedge clk);
        checkOutput("skid ready after 1st", {31'd0, bus.ready_o}, 1);
        applyStimulus(1'b1, 3'd2, 3'b001, 7'd0);
        @(negedge clk);
        checkOutput("skid ready after 2nd", {31'd0, bus.ready_o}, 0);
        checkOutput("skid head ctrl", {27'd0, bus.alu_ctrl_o}, 10);
        applyStimulus(1'b1, 3'd2, 3'b100, 7'd0);
        @(negedge clk);
        checkOutput("skid stall ready", {31'd0, bus.ready_o}, 0);
        checkOutput("skid stall valid", {31'd0, bus.valid_o}, 1);
        checkOutput("skid stall ctrl", {27'd0, bus.alu_ctrl_o}, 10);
        bus.ready_i = 1'b1;
        @(negedge clk);
        checkOutput("skid drain ctrl", {27'd0, bus.alu_ctrl_o}, 11);
        checkOutput("skid drain ready", {31'd0, bus.ready_o}, 1);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 3'd0, 7'd0);
        checkOutput("skid reaccept ctrl", {27'd0, bus.alu_ctrl_o}, 12);
        checkOutput("skid reaccept valid", {31'd0, bus.valid_o}, 1);
        @(negedge clk);
        checkOutput("skid empty valid", {31'd0, bus.valid_o}, 0);

        $display("[TB] flush in TWO with input");
        bus.ready_i = 1'b0;
        applyStimulus(1'b1, 3'd3, 3'd0, 7'd0);
        @(negedge clk);
        applyStimulus(1'b1, 3'd6, 3'd0, 7'd0);
        @(negedge clk);
        checkOutput("flush pre ready", {31'd0, bus.ready_o}, 0);
        applyStimulus(1'b1, 3'd0, 3'b111, 7'd0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        applyStimulus(1'b0, 3'd0, 3'd0, 7'd0);
        checkOutput("flush2 valid_o", {31'd0, bus.valid_o}, 0);
        checkOutput("flush2 ready_o", {31'd0, bus.ready_o}, 1);
        checkOutput("flush2 ctrl", {27'd0, bus.alu_ctrl_o}, 0);
        @(negedge clk);
        checkOutput("flush2 discard", {31'd0, bus.valid_o}, 0);

        $display("[TB] flush in ONE with input");
        applyStimulus(1'b1, 3'd3, 3'd0, 7'd0);
        @(negedge clk);
        applyStimulus(1'b1, 3'd0, 3'b110, 7'd0);
        bus.flush_i = 1'b1;
        @(negedge clk);
        bus.flush_i = 1'b0;
        applyStimulus(1'b0, 3'd0, 3'd0, 7'd0);
        checkOutput("flush1 valid_o", {31'd0, bus.valid_o}, 0);
        checkOutput("flush1 ready_o", {31'd0, bus.ready_o}, 1);
        @(negedge clk);
        checkOutput("flush1 discard", {31'd0, bus.valid_o}, 0);

        $display("[TB] reset while in ONE");
        applyStimulus(1'b1, 3'd3, 3'd0, 7'd0);
        @(negedge clk);
        applyStimulus(1'b0, 3'd0, 3'd0, 7'd0);
        checkOutput("rst pre ctrl", {27'd0, bus.alu_ctrl_o}, 17);
        rst = 1'b1;
        bus.flush_i = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.flush_i = 1'b0;
        checkOutput("rst valid_o", {31'd0, bus.valid_o}, 0);
        checkOutput("rst alu_ctrl_o", {27'd0, bus.alu_ctrl_o}, 0);
        checkOutput("rst ready_o", {31'd0, bus.ready_o}, 0);
        @(negedge clk);
        checkOutput("rst release ready_o", {31'd0, bus.ready_o}, 1);
        checkOutput("rst release valid_o", {31'd0, bus.valid_o}, 0);

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

endmodule

// File: doc/alu_ctrl_stage.md
ALU_CTRL_STAGE -- requirements
Module: alu_ctrl_stage

Interface
REQ-001 SHALL have one clock and synchronous active-high reset: clk_i (posedge clock) and rst_i (synchronous, active-high).
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  1  upstream aluop/funct fields valid
- ready_o  out  1  stage can accept
- aluop_i  in  3  0=R, 1=I, 2=BRANCH, 3=JAL/JALR, 4=LOAD, 5=STORE, 6=LUI, 7=reserved
- funct3_i  in  3  instruction funct3
- funct7_i  in  7  instruction funct7
- valid_o  out  1  alu_ctrl_o valid
- ready_i  in  1  downstream accepts
- alu_ctrl_o  out  5  ALU operation code
- illegal_o  out  1  illegal combination flag
- flush_i  in  1  discard all buffered entries

Function
REQ-003 alu_ctrl_o codes SHALL be: 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 BEQ, 11 BNE, 12 BLT, 13 BGE, 14 BLTU, 15 BGEU, 16 PASSB, 17 JUMP; codes 18-31 never driven.
REQ-004 aluop=0 SHALL decode funct3 as follows:
- 000: SUB if funct7[5] is set, else ADD
- 001: SLL
- 010: SLT
- 011: SLTU
- 100: XOR
- 101: SRA if funct7[5] is set, else SRL
- 110: OR
- 111: AND
REQ-005 aluop=1 SHALL decode as REQ-004, except funct3=000 is always ADD.
REQ-006 aluop=2 SHALL map funct3 000/001/100/101/110/111 to BEQ/BNE/BLT/BGE/BLTU/BGEU; funct3 010/011 are illegal.
REQ-007 aluop=3 SHALL give JUMP; aluop=4 or 5 SHALL give ADD; aluop=6 SHALL give PASSB; aluop=7 is illegal.
REQ-008 An illegal combination SHALL produce ADD on alu_ctrl_o.
REQ-009 Input transfer SHALL occur when valid_i and ready_o are both high on a clock edge; output transfer SHALL occur when valid_o and ready_i are both high.
REQ-010 The stage SHALL be a 2-entry skid buffer: output register OUT plus skid register SKID, with decode performed before the register.
REQ-011 The FSM SHALL have three states: EMPTY (0 entries), ONE (OUT valid), TWO (OUT and SKID valid).
REQ-012 Latency SHALL be 1 cycle: data accepted at edge N appears on alu_ctrl_o after edge N when OUT was empty or drained at edge N.
REQ-013 ready_o SHALL be a registered signal, high in EMPTY and ONE and low in TWO.
REQ-014 FSM transitions SHALL be:
- EMPTY with input transfer -> ONE
- ONE with input transfer and no output transfer -> TWO, new entry into SKID
- ONE with input and output transfer -> ONE, new entry into OUT
- ONE with output transfer only -> EMPTY
- TWO with output transfer -> ONE, SKID moved into OUT
REQ-015 Ordering SHALL be strict FIFO; no entry is dropped or duplicated.
REQ-016 flush_i SHALL clear OUT and SKID and go to EMPTY at the next edge.
REQ-017 flush_i SHALL take priority over simultaneous input or output transfers; an input presented during flush is discarded.
REQ-018 valid_o SHALL be high exactly in ONE and TWO; alu_ctrl_o and illegal_o SHALL hold stable while valid_o is high and ready_i is low.

Reset
REQ-019 rst_i SHALL force state EMPTY, valid_o=0, ready_o=0, alu_ctrl_o=0, illegal_o=0 on the reset edge.
REQ-020 ready_o SHALL rise on the first edge after rst_i deasserts.
REQ-021 Reset mid-operation SHALL discard all buffered entries.
REQ-022 rst_i SHALL have priority over flush_i.

Configuration
REQ-023 Macro ALU_CTRL_ILLEGAL_EN SHALL control illegal-combination detection.
REQ-024 With ALU_CTRL_ILLEGAL_EN defined, illegal_o SHALL be registered alongside each entry and set for:
- aluop=7
- branch funct3 010/011
- R-type funct7 not 0000000 or 0100000
- R-type funct7=0100000 with funct3 not 000/101
- I-type shift (funct3 001/101) with funct7 other than 0000000, or 0100000 for 101
REQ-025 Without ALU_CTRL_ILLEGAL_EN, illegal_o SHALL be tied 0 and no illegal-flag storage SHALL exist; alu_ctrl_o is unchanged.

Verification
REQ-026 Directed scenarios the bench SHALL cover:
- aluop=0, funct3=000, funct7=0100000, ready_i=1 -> alu_ctrl_o=1 (SUB) one cycle later, valid_o pulses 1 cycle.
- aluop=1, funct3=000, funct7=0100000 -> alu_ctrl_o=0 (ADD); aluop=1, funct3=101, funct7=0100000 -> 7 (SRA).
- ready_i=0, three back-to-back inputs (aluop=2 with funct3 000, 001, 100) -> ready_o low after the 2nd; then ready_i=1 -> outputs 10, 11 in order, then 12 after re-accept.
- State TWO with flush_i=1 and valid_i=1 in the same cycle -> next cycle valid_o=0, ready_o=1, input discarded.
- rst_i asserted while in ONE -> valid_o=0, alu_ctrl_o=0, ready_o=0, then ready_o=1 one cycle after release.
- aluop=7 with ALU_CTRL_ILLEGAL_EN -> alu_ctrl_o=0, illegal_o=1; same stimulus without the macro -> illegal_o=0.
